// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions for the TX data packer.
// Holds the lane slot geometry, the generation encodings, the packer state
// type and the generation-to-PIPE-width lookup.
package pcie_phy_pkg;

    localparam int MAX_LANES       = 16;
    localparam int LANE_SLOT_BITS  = 32;
    localparam int LANE_SLOT_KBITS = 4;

    localparam logic [2:0] GEN1 = 3'd1;
    localparam logic [2:0] GEN2 = 3'd2;
    localparam logic [2:0] GEN3 = 3'd3;
    localparam logic [2:0] GEN4 = 3'd4;
    localparam logic [2:0] GEN5 = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } packer_state_e;

    // Per-generation PIPE width; the widths come from the instantiating
    // block so they stay overridable there. Unknown generations give 0.
    function automatic logic [5:0] pipe_width(input logic [2:0] gen,
                                              input logic [5:0] w1,
                                              input logic [5:0] w2,
                                              input logic [5:0] w3,
                                              input logic [5:0] w4,
                                              input logic [5:0] w5);
        case (gen)
            GEN1:    return w1;
            GEN2:    return w2;
            GEN3:    return w3;
            GEN4:    return w4;
            GEN5:    return w5;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/tx_data_packer_lane.sv
// tx_lane_accumulator: one lane's 32-bit data slot plus 4 K-flag bits.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   i_wr               - write this beat into the slot
//   i_off              - byte offset of the beat within the slot
//   i_nbytes           - beat size in bytes (1, 2 or 4)
//   i_data, i_k        - lane beat, byte 0 / K bit 0 are the beat's first byte
//   o_data, o_k        - slot contents with the current beat already merged
module tx_lane_accumulator
    import pcie_phy_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr,
    input  logic [1:0]                 i_off,
    input  logic [2:0]                 i_nbytes,
    input  logic [LANE_SLOT_BITS-1:0]  i_data,
    input  logic [LANE_SLOT_KBITS-1:0] i_k,
    output logic [LANE_SLOT_BITS-1:0]  o_data,
    output logic [LANE_SLOT_KBITS-1:0] o_k
);

    logic [LANE_SLOT_BITS-1:0]  r_data, w_data;
    logic [LANE_SLOT_KBITS-1:0] r_k, w_k;
    logic [1:0]                 w_rel;

    // w_rel wraps mod 4; because off+nbytes never exceeds 4, slot bytes
    // below the offset wrap to a value >= nbytes and are left untouched.
    always_comb begin
        w_data = r_data;
        w_k    = r_k;
        w_rel  = 2'd0;
        if (i_wr) begin
            for (int b = 0; b < LANE_SLOT_KBITS; b++) begin
                w_rel = 2'(b) - i_off;
                if ({1'b0, w_rel} < i_nbytes) begin
                    w_data[8*b +: 8] = i_data[{w_rel, 3'b000} +: 8];
                    w_k[b]           = i_k[w_rel];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_k    <= '0;
        end else if (i_wr) begin
            r_data <= w_data;
            r_k    <= w_k;
        end
    end

    assign o_data = w_data;
    assign o_k    = w_k;

endmodule

// File: rtl/tx_data_packer.sv
// tx_data_packer: gathers per-lane PIPE TX beats into 32-bit lane slots and
// hands a lane-aligned 512-bit word plus 64 K-flags to the TX lane manager.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   GEN, LANESNUMBER     - link generation (1..5), active lanes (1,2,4,8,16)
//   pipeData, pipeDataK  - lane i beat in pipeData[32i +: PIPEWIDTH], K in [4i +: PIPEWIDTH/8]
//   pipeValid/pipeReady  - PIPE-side handshake
//   lmcOut, lmcOutK      - packed word, active lanes in the top N slots
//   lmcValid/lmcReady    - lane-manager-side handshake
//   PIPEWIDTH            - active per-lane width, 0 for an unknown GEN
//   cfgErr               - one-cycle pulse when a partial word is dropped
module tx_data_packer
    import pcie_phy_pkg::*;
#(
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 16,
    parameter int GEN3_PIPEWIDTH = 32,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
)(
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   GEN,
    input  logic [4:0]   LANESNUMBER,
    input  logic [511:0] pipeData,
    input  logic [63:0]  pipeDataK,
    input  logic         pipeValid,
    output logic         pipeReady,
    output logic [511:0] lmcOut,
    output logic [63:0]  lmcOutK,
    output logic         lmcValid,
    input  logic         lmcReady,
    output logic [5:0]   PIPEWIDTH,
    output logic         cfgErr
);

    packer_state_e r_state, w_state_nxt;
    logic [1:0]    r_cnt, w_cnt_nxt;
    logic [2:0]    r_gen;
    logic [4:0]    r_lanes;
    logic [511:0]  r_out;
    logic [63:0]   r_outk;
    logic          r_valid, r_cfg_err;

    logic [5:0]    w_pw;
    logic          w_cfg_ok, w_cfg_chg, w_last;
    logic [1:0]    w_off, w_last_cnt;
    logic [2:0]    w_nbytes;
    logic          w_wr, w_done, w_load, w_drop, w_latch;
    logic [4:0]    w_lanes_eff, w_sh;

    logic [MAX_LANES-1:0][LANE_SLOT_BITS-1:0]  w_lane_d;
    logic [MAX_LANES-1:0][LANE_SLOT_KBITS-1:0] w_lane_k;
    logic [511:0]  w_flat_d, w_aligned_d;
    logic [63:0]   w_flat_k, w_aligned_k;

    assign w_pw = pipe_width(GEN, 6'(GEN1_PIPEWIDTH), 6'(GEN2_PIPEWIDTH),
                             6'(GEN3_PIPEWIDTH), 6'(GEN4_PIPEWIDTH), 6'(GEN5_PIPEWIDTH));

    always_comb begin
        w_cfg_ok = (w_pw == 6'd8 || w_pw == 6'd16 || w_pw == 6'd32) &&
                   (LANESNUMBER == 5'd1 || LANESNUMBER == 5'd2 || LANESNUMBER == 5'd4 ||
                    LANESNUMBER == 5'd8 || LANESNUMBER == 5'd16);
        w_cfg_chg = (GEN != r_gen) || (LANESNUMBER != r_lanes);
        case (w_pw)
            6'd8:    begin w_nbytes = 3'd1; w_last_cnt = 2'd3; w_off = r_cnt;            end
            6'd16:   begin w_nbytes = 3'd2; w_last_cnt = 2'd1; w_off = {r_cnt[0], 1'b0}; end
            default: begin w_nbytes = 3'd4; w_last_cnt = 2'd0; w_off = 2'd0;             end
        endcase
        w_last = (r_cnt == w_last_cnt);
    end

    // Next-state / handshake. In FILL the live config equals the latched
    // one (otherwise the word is dropped), so w_pw is the word's width.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        pipeReady   = 1'b0;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_latch     = 1'b0;
        w_lanes_eff = r_lanes;
        case (r_state)
            IDLE: begin
                pipeReady   = w_cfg_ok;
                w_lanes_eff = LANESNUMBER;
                if (pipeValid && w_cfg_ok) begin
                    w_wr    = 1'b1;
                    w_latch = 1'b1;
                    if (w_last) w_done = 1'b1;
                    else begin
                        w_state_nxt = FILL;
                        w_cnt_nxt   = 2'd1;
                    end
                end
            end
            FILL: begin
                if (w_cfg_chg) begin
                    w_drop      = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    pipeReady = 1'b1;
                    if (pipeValid) begin
                        w_wr = 1'b1;
                        if (w_last) w_done = 1'b1;
                        else        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (lmcReady) begin
                    w_load      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A finished word goes straight out if the output slot is free or
        // being emptied this cycle; otherwise it waits in the accumulators.
        if (w_done) begin
            w_cnt_nxt = 2'd0;
            if (!r_valid || lmcReady) begin
                w_load      = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = HOLD;
            end
        end
    end

    for (genvar g = 0; g < MAX_LANES; g++) begin : g_lane
        tx_lane_accumulator u_acc (
            .clk      (clk),
            .reset    (reset),
            .i_wr     (w_wr),
            .i_off    (w_off),
            .i_nbytes (w_nbytes),
            .i_data   (pipeData[LANE_SLOT_BITS*g +: LANE_SLOT_BITS]),
            .i_k      (pipeDataK[LANE_SLOT_KBITS*g +: LANE_SLOT_KBITS]),
            .o_data   (w_lane_d[g]),
            .o_k      (w_lane_k[g])
        );
    end

    // Left shift by 16-N slots: active lanes land in the top N slots,
    // inactive lanes fall off the top and the low slots fill with zeros.
    assign w_flat_d    = w_lane_d;
    assign w_flat_k    = w_lane_k;
    assign w_sh        = 5'd16 - w_lanes_eff;
    assign w_aligned_d = w_flat_d << {w_sh, 5'b00000};
    assign w_aligned_k = w_flat_k << {w_sh, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_gen     <= 3'd0;
            r_lanes   <= 5'd0;
            r_out     <= '0;
            r_outk    <= '0;
            r_valid   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cfg_err <= w_drop;
            if (w_latch) begin
                r_gen   <= GEN;
                r_lanes <= LANESNUMBER;
            end
            if (w_load) begin
                r_out   <= w_aligned_d;
                r_outk  <= w_aligned_k;
                r_valid <= 1'b1;
            end else if (lmcReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign lmcOut    = r_out;
    assign lmcOutK   = r_outk;
    assign lmcValid  = r_valid;
    assign PIPEWIDTH = w_pw;
    assign cfgErr    = r_cfg_err;

endmodule

// File: tb/tb_tx_data_packer.sv
module tb_tx_data_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   GEN;
    logic [4:0]   LANESNUMBER;
    logic [511:0] pipeData;
    logic [63:0]  pipeDataK;
    logic         pipeValid, pipeReady;
    logic [511:0] lmcOut;
    logic [63:0]  lmcOutK;
    logic         lmcValid, lmcReady;
    logic [5:0]   PIPEWIDTH;
    logic         cfgErr;

    always #5 clk = ~clk;

    tx_data_packer dut (
        .clk(clk), .reset(reset), .GEN(GEN), .LANESNUMBER(LANESNUMBER),
        .pipeData(pipeData), .pipeDataK(pipeDataK), .pipeValid(pipeValid),
        .pipeReady(pipeReady), .lmcOut(lmcOut), .lmcOutK(lmcOutK),
        .lmcValid(lmcValid), .lmcReady(lmcReady), .PIPEWIDTH(PIPEWIDTH),
        .cfgErr(cfgErr)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
    } word_t;

    // Reference model: beats of the word being gathered, and completed words
    // not yet taken downstream (front = the one on lmcOut).
    word_t      pb[$];
    word_t      pend[$];
    logic [2:0] m_gen;
    logic [4:0] m_lanes;
    logic       m_err_exp = 1'b0;
    int         n_words_out = 0;
    int         n_cfgerr_seen = 0;

    function automatic int m_pw(input logic [2:0] g);
        case (g)
            3'd1: return 8;
            3'd2: return 16;
            3'd3: return 32;
            3'd4: return 8;
            3'd5: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_lanes_ok(input logic [4:0] l);
        return l == 5'd1 || l == 5'd2 || l == 5'd4 || l == 5'd8 || l == 5'd16;
    endfunction

    // Lane i, beat b, byte k goes to byte (b*nb+k) of output slot i+16-N.
    function automatic word_t build_word();
        word_t w;
        int pw, nb, bpw, n;
        pw  = m_pw(m_gen);
        nb  = pw / 8;
        bpw = 32 / pw;
        n   = int'(m_lanes);
        w.d = '0;
        w.k = '0;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < bpw; b++)
                for (int k = 0; k < nb; k++) begin
                    w.d[32*(i+16-n) + 8*(b*nb+k) +: 8] = pb[b].d[32*i + 8*k +: 8];
                    w.k[4*(i+16-n) + b*nb + k]         = pb[b].k[4*i + k];
                end
        return w;
    endfunction

    task automatic rand_data();
        for (int j = 0; j < 16; j++) pipeData[32*j +: 32] = $urandom;
        pipeDataK = {$urandom, $urandom};
    endtask

    // One clock: compare DUT against the model, advance the model, step.
    // Called at a falling edge with the cycle's inputs already driven.
    task automatic cyc();
        int   pw;
        logic cfg_ok, changed, exp_ready;
        #1;
        n_checks++;
        if (lmcValid !== (pend.size() != 0)) begin
            n_errors++;
            $display("FAIL lmc_valid: got %b exp %b", lmcValid, pend.size() != 0);
        end
        if (pend.size() != 0) begin
            n_checks++;
            if (lmcOut !== pend[0].d || lmcOutK !== pend[0].k) begin
                n_errors++;
                $display("FAIL lmc_word: got %h/%h exp %h/%h", lmcOut, lmcOutK, pend[0].d, pend[0].k);
            end
        end
        n_checks++;
        if (cfgErr !== m_err_exp) begin
            n_errors++;
            $display("FAIL cfg_err: got %b exp %b", cfgErr, m_err_exp);
        end
        if (cfgErr === 1'b1) n_cfgerr_seen++;
        pw = m_pw(GEN);
        n_checks++;
        if (PIPEWIDTH !== 6'(pw)) begin
            n_errors++;
            $display("FAIL pipewidth: got %0d exp %0d", PIPEWIDTH, pw);
        end
        cfg_ok    = (pw == 8 || pw == 16 || pw == 32) && m_lanes_ok(LANESNUMBER);
        changed   = (pb.size() > 0) && (GEN !== m_gen || LANESNUMBER !== m_lanes);
        exp_ready = cfg_ok && pend.size() < 2 && !changed;
        n_checks++;
        if (pipeReady !== exp_ready) begin
            n_errors++;
            $display("FAIL pipe_ready: got %b exp %b", pipeReady, exp_ready);
        end
        if (reset) begin
            pb.delete();
            pend.delete();
            m_err_exp = 1'b0;
        end else begin
            m_err_exp = changed;
            if (lmcReady && pend.size() > 0) begin
                void'(pend.pop_front());
                n_words_out++;
            end
            if (changed) pb.delete();
            else if (pipeValid && exp_ready) begin
                if (pb.size() == 0) begin
                    m_gen   = GEN;
                    m_lanes = LANESNUMBER;
                end
                pb.push_back('{pipeData, pipeDataK});
                if (pb.size() == 32 / pw) begin
                    pend.push_back(build_word());
                    pb.delete();
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (lmcValid !== 1'b0 || cfgErr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got valid=%b err=%b exp 0 0", lmcValid, cfgErr);
        end
        n_checks++;
        if (lmcOut !== 512'd0 || lmcOutK !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_data: got %h/%h exp 0", lmcOut, lmcOutK);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_gen1_x16();
        int drops = 0;
        GEN = 3'd1; LANESNUMBER = 5'd16; lmcReady = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rand_data();
            for (int i = 0; i < 16; i++) pipeData[32*i +: 8] = 8'(b*16 + i);
            pipeValid = 1'b1;
            #1;
            if (pipeReady !== 1'b1) drops++;
            cyc();
        end
        pipeValid = 1'b0;
        n_checks++;
        if (lmcValid !== 1'b1 || lmcOut[31:0] !== 32'h30201000) begin
            n_errors++;
            $display("FAIL gen1_lane0: got v=%b %h exp 1 30201000", lmcValid, lmcOut[31:0]);
        end
        n_checks++;
        if (lmcOut[511:480] !== 32'h3F2F1F0F) begin
            n_errors++;
            $display("FAIL gen1_lane15: got %h exp 3f2f1f0f", lmcOut[511:480]);
        end
        n_checks++;
        if (drops != 0) begin
            n_errors++;
            $display("FAIL gen1_ready: got %0d drops exp 0", drops);
        end
        cyc();
    endtask

    task automatic test_gen3_x4();
        int w0 = n_words_out;
        GEN = 3'd3; LANESNUMBER = 5'd4; lmcReady = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rand_data();
            pipeData[31:0] = 32'hDEADBEEF;
            pipeDataK[3:0] = 4'h1;
            pipeValid = 1'b1;
            cyc();
            n_checks++;
            if (lmcValid !== 1'b1 || lmcOut[415:384] !== 32'hDEADBEEF || lmcOutK[51:48] !== 4'h1) begin
                n_errors++;
                $display("FAIL gen3_slot12: got v=%b %h k=%h exp 1 deadbeef 1", lmcValid, lmcOut[415:384], lmcOutK[51:48]);
            end
            n_checks++;
            if (lmcOut[383:0] !== 384'd0 || lmcOutK[47:0] !== 48'd0) begin
                n_errors++;
                $display("FAIL gen3_low_zero: got %h exp 0", lmcOut[383:0]);
            end
        end
        pipeValid = 1'b0;
        cyc();
        n_checks++;
        if (n_words_out - w0 != 4) begin
            n_errors++;
            $display("FAIL gen3_rate: got %0d words exp 4", n_words_out - w0);
        end
    endtask

    task automatic test_gen2_hold();
        logic [511:0] snap;
        int w0 = n_words_out;
        GEN = 3'd2; LANESNUMBER = 5'd1; lmcReady = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rand_data();
            pipeValid = 1'b1;
            cyc();
        end
        #1;
        n_checks++;
        if (pipeReady !== 1'b0 || lmcValid !== 1'b1) begin
            n_errors++;
            $display("FAIL gen2_hold: got ready=%b valid=%b exp 0 1", pipeReady, lmcValid);
        end
        snap = lmcOut;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            cyc();
        end
        n_checks++;
        if (lmcOut !== snap) begin
            n_errors++;
            $display("FAIL gen2_stable: got %h exp %h", lmcOut[31:0], snap[31:0]);
        end
        pipeValid = 1'b0;
        lmcReady = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        n_checks++;
        if (n_words_out - w0 != 2 || lmcValid !== 1'b0) begin
            n_errors++;
            $display("FAIL gen2_drain: got %0d words valid=%b exp 2 0", n_words_out - w0, lmcValid);
        end
    endtask

    task automatic test_cfg_change();
        int w0 = n_words_out;
        int e0 = n_cfgerr_seen;
        GEN = 3'd1; LANESNUMBER = 5'd8; lmcReady = 1'b1;
        for (int b = 0; b < 2; b++) begin
            rand_data();
            pipeValid = 1'b1;
            cyc();
        end
        LANESNUMBER = 5'd4;
        rand_data();
        cyc();
        for (int b = 0; b < 4; b++) begin
            rand_data();
            cyc();
        end
        pipeValid = 1'b0;
        n_checks++;
        if (lmcValid !== 1'b1 || lmcOut[383:0] !== 384'd0) begin
            n_errors++;
            $display("FAIL cfg_slots: got v=%b low=%h exp 1 0", lmcValid, lmcOut[383:0]);
        end
        cyc();
        cyc();
        n_checks++;
        if (n_cfgerr_seen - e0 != 1 || n_words_out - w0 != 1) begin
            n_errors++;
            $display("FAIL cfg_drop: got %0d pulses %0d words exp 1 1", n_cfgerr_seen - e0, n_words_out - w0);
        end
    endtask

    task automatic test_invalid();
        GEN = 3'd6; LANESNUMBER = 5'd16; lmcReady = 1'b1; pipeValid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin GEN = 3'd1; LANESNUMBER = 5'd3; end
            rand_data();
            #1;
            n_checks++;
            if (pipeReady !== 1'b0 || lmcValid !== 1'b0 || (c < 4 && PIPEWIDTH !== 6'd0)) begin
                n_errors++;
                $display("FAIL invalid_cfg: got ready=%b valid=%b pw=%0d exp 0 0", pipeReady, lmcValid, PIPEWIDTH);
            end
            cyc();
        end
        pipeValid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w0;
        GEN = 3'd1; LANESNUMBER = 5'd16; lmcReady = 1'b0;
        for (int b = 0; b < 7; b++) begin
            rand_data();
            pipeValid = 1'b1;
            cyc();
        end
        pipeValid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_checks++;
        if (lmcValid !== 1'b0 || lmcOut !== 512'd0 || lmcOutK !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got valid=%b out=%h exp 0 0", lmcValid, lmcOut[63:0]);
        end
        w0 = n_words_out;
        lmcReady = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rand_data();
            pipeValid = 1'b1;
            cyc();
        end
        pipeValid = 1'b0;
        cyc();
        n_checks++;
        if (n_words_out - w0 != 1) begin
            n_errors++;
            $display("FAIL reset_fresh: got %0d words exp 1", n_words_out - w0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    GEN         = 3'($urandom_range(0, 7));
                    LANESNUMBER = 5'($urandom_range(0, 31));
                end else begin
                    GEN         = 3'($urandom_range(1, 5));
                    LANESNUMBER = 5'(1 << $urandom_range(0, 4));
                end
            end
            pipeValid = ($urandom_range(0, 3) != 0);
            lmcReady  = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 399) == 0);
            rand_data();
            cyc();
        end
        reset = 1'b0;
        pipeValid = 1'b0;
        lmcReady = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        n_checks++;
        if (lmcValid !== 1'b0) begin
            n_errors++;
            $display("FAIL random_drain: got valid=%b exp 0", lmcValid);
        end
    endtask

    initial begin
        reset = 1'b1;
        GEN = 3'd1;
        LANESNUMBER = 5'd16;
        pipeData = '0;
        pipeDataK = '0;
        pipeValid = 1'b0;
        lmcReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_gen1_x16();
        test_gen3_x4();
        test_gen2_hold();
        test_cfg_change();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
